// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding, shift kinds.
// The ALU control decoder uses the same op codes.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_t;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic shift_t shift_type_of(input logic [OP_W-1:0] op);
    shift_t t;
    t = SH_SLL;
    if (op == OP_SRL) t = SH_SRL;
    if (op == OP_SRA) t = SH_SRA;
    return t;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter; the caller limits the amount to the
// per-cycle step size.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 1
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [AMT_W-1:0] i_amount,
  input  shift_t           i_type,
  output logic [WIDTH-1:0] o_value
);

  always_comb begin
    o_value = i_value;
    unique case (i_type)
      SH_SLL:  o_value = i_value << i_amount;
      SH_SRL:  o_value = i_value >> i_amount;
      SH_SRA:  o_value = WIDTH'($signed(i_value) >>> i_amount);
      default: o_value = i_value;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative shifts,
// start/busy/done handshake and zero/illegal flags held with the result.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned AMT_W = $clog2(SHIFT_STEP + 1);
  localparam int unsigned CNT_W = SHAMT_W;
  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(SHIFT_STEP);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_shift_val;
  shift_t           r_shift_type;
  logic             r_done;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_illegal;

  logic             w_in_shift;
  logic             w_accept;
  logic             w_is_shift;
  logic             w_last_step;
  logic             w_done_set;
  logic             w_core_illegal;
  logic             w_final_illegal;
  logic [CNT_W-1:0] w_step_src;
  logic [CNT_W-1:0] w_step_cnt;
  logic [CNT_W-1:0] w_count_rem;
  logic [AMT_W-1:0] w_step_amt;
  logic [WIDTH-1:0] w_shift_in;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_core_res;
  logic [WIDTH-1:0] w_final_res;
  shift_t           w_shift_type;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_accept   = start && !w_in_shift;
  assign w_is_shift = is_shift_op(operation);

  // First shift step happens on the accept edge; later steps come from the latched working value.
  always_comb begin
    w_step_src   = w_in_shift ? r_count : in_b[CNT_W-1:0];
    w_step_cnt   = (w_step_src > STEP_CNT) ? STEP_CNT : w_step_src;
    w_step_amt   = AMT_W'(w_step_cnt);
    w_count_rem  = w_step_src - w_step_cnt;
    w_last_step  = (w_count_rem == '0);
    w_shift_in   = w_in_shift ? r_shift_val : in_a;
    w_shift_type = w_in_shift ? r_shift_type : shift_type_of(operation);
  end

  alu_shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_shift_step (
    .i_value  (w_shift_in),
    .i_amount (w_step_amt),
    .i_type   (w_shift_type),
    .o_value  (w_shifted)
  );

  // Single-cycle datapath
  always_comb begin
    w_core_res     = '0;
    w_core_illegal = 1'b0;
    unique case (operation)
      OP_AND:  w_core_res = in_a & in_b;
      OP_OR:   w_core_res = in_a | in_b;
      OP_ADD:  w_core_res = in_a + in_b;
      OP_SUB:  w_core_res = in_a - in_b;
      OP_XOR:  w_core_res = in_a ^ in_b;
      OP_SLT:  w_core_res = WIDTH'($signed(in_a) < $signed(in_b));
      OP_SLTU: w_core_res = WIDTH'(in_a < in_b);
      OP_SLL, OP_SRL, OP_SRA: w_core_res = '0;
      default: w_core_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept && w_is_shift && !w_last_step) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last_step) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = w_in_shift;
    w_done_set      = w_in_shift ? w_last_step : (w_accept && !(w_is_shift && !w_last_step));
    w_final_res     = (w_in_shift || w_is_shift) ? w_shifted : w_core_res;
    w_final_illegal = !w_in_shift && w_core_illegal;
  end

  // Shift working state; also advances on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_shift_val  <= '0;
      r_shift_type <= SH_SLL;
    end else begin
      if (w_in_shift || (w_accept && w_is_shift)) begin
        r_shift_val <= w_shifted;
        r_count     <= w_count_rem;
      end
      if (w_accept && w_is_shift) r_shift_type <= w_shift_type;
    end
  end

  // Result and flags change only on the done edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_alu_out <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_done_set) begin
        r_alu_out <= w_final_res;
        r_zero    <= (w_final_res == '0);
        r_illegal <= w_final_illegal;
      end
    end
  end

  assign done    = r_done;
  assign alu_out = r_alu_out;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int unsigned STEP    = 1;
  localparam int          TIMEOUT = 100;

  localparam logic [3:0] T_AND  = 4'b0000;
  localparam logic [3:0] T_OR   = 4'b0001;
  localparam logic [3:0] T_ADD  = 4'b0010;
  localparam logic [3:0] T_SUB  = 4'b0110;
  localparam logic [3:0] T_XOR  = 4'b0011;
  localparam logic [3:0] T_SLL  = 4'b0100;
  localparam logic [3:0] T_SRL  = 4'b1000;
  localparam logic [3:0] T_SRA  = 4'b1001;
  localparam logic [3:0] T_SLT  = 4'b0101;
  localparam logic [3:0] T_SLTU = 4'b0111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  operation;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        busy;
  logic        done;
  logic [31:0] alu_out;
  logic        zero;
  logic        illegal;

  int checks;
  int errors;

  alu_multicycle #(
    .WIDTH      (32),
    .SHIFT_STEP (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operation (operation),
    .in_a      (in_a),
    .in_b      (in_b),
    .busy      (busy),
    .done      (done),
    .alu_out   (alu_out),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned k;
    sa = a;
    sb = b;
    k  = {27'd0, b[4:0]};
    case (op)
      T_AND:   return a & b;
      T_OR:    return a | b;
      T_ADD:   return a + b;
      T_SUB:   return a - b;
      T_XOR:   return a ^ b;
      T_SLL:   return a << k;
      T_SRL:   return a >> k;
      T_SRA:   return 32'(sa >>> k);
      T_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      T_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [3:0] op);
    return !(op inside {T_AND, T_OR, T_ADD, T_SUB, T_XOR, T_SLL, T_SRL, T_SRA, T_SLT, T_SLTU});
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    int k;
    k = {27'd0, b[4:0]};
    if (op == T_SLL || op == T_SRL || op == T_SRA) begin
      if (k == 0) return 1;
      return (k + int'(STEP) - 1) / int'(STEP);
    end
    return 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge; returns #1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    operation = op;
    in_a      = a;
    in_b      = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    operation = 4'($urandom_range(0, 15));
    in_a      = $urandom;
    in_b      = $urandom;
  endtask

  // Called #1 after the accept edge; returns #1 after the edge that raised done.
  task automatic wait_done(input string tag, input logic [31:0] exp_out, input logic exp_ill,
                           input int exp_lat);
    int lat;
    int busy_cnt;
    lat      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_out"}, 64'(alu_out), 64'(exp_out));
    check({tag, "_zero"}, 64'(zero), 64'(exp_out == 32'd0));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] held;
    int          gap;

    checks    = 0;
    errors    = 0;
    start     = 1'b0;
    operation = 4'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out", 64'(alu_out), 64'd0);
    check("reset_zero", 64'(zero), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(T_ADD, 32'd7, 32'd5);
    wait_done("add", 32'd12, 1'b0, 1);
    issue(T_SUB, 32'd9, 32'd9);
    wait_done("sub_zero", 32'd0, 1'b0, 1);
    issue(T_SLT, 32'hFFFF_FFFF, 32'd1);
    wait_done("slt", 32'd1, 1'b0, 1);
    issue(T_SLTU, 32'hFFFF_FFFF, 32'd1);
    wait_done("sltu", 32'd0, 1'b0, 1);
    issue(T_SRA, 32'h8000_0000, 32'd31);
    wait_done("sra31", 32'hFFFF_FFFF, 1'b0, 31);
    issue(T_SLL, 32'hDEAD_BEEF, 32'd0);
    wait_done("sll0", 32'hDEAD_BEEF, 1'b0, 1);

    // start held high and operands changed while shifting
    @(negedge clk);
    start     = 1'b1;
    operation = T_SLL;
    in_a      = 32'd3;
    in_b      = 32'd5;
    @(posedge clk);
    #1;
    operation = T_ADD;
    in_a      = 32'd1;
    in_b      = 32'd2;
    wait_done("sll_held_start", 32'h60, 1'b0, 5);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("sll_held_single_done", 64'(done), 64'd0);
    check("sll_held_out_kept", 64'(alu_out), 64'h60);

    // reset in the middle of a long shift
    issue(T_SLL, 32'd1, 32'd20);
    check("mid_shift_busy", 64'(busy), 64'd1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_out", 64'(alu_out), 64'd0);
    check("rst_mid_zero", 64'(zero), 64'd0);
    check("rst_mid_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;
    check("rst_hold_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(T_ADD, 32'd7, 32'd5);
    wait_done("add_after_rst", 32'd12, 1'b0, 1);

    // illegal op, then back-to-back requests issued in the done cycle
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done("illegal", 32'd0, 1'b1, 1);
    issue(T_ADD, 32'd100, 32'd23);
    wait_done("b2b_add", 32'd123, 1'b0, 1);
    issue(T_SRL, 32'hF0, 32'd4);
    wait_done("b2b_srl", 32'hF, 1'b0, 4);
    issue(T_SLL, 32'd1, 32'd3);
    wait_done("b2b_sll", 32'd8, 1'b0, 3);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {31'd0, a[0]};
      issue(op, a, b);
      wait_done($sformatf("rnd%0d_op%0h", i, op), ref_result(op, a, b), ref_illegal(op),
                ref_latency(op, b));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        held = ref_result(op, a, b);
        repeat (gap) @(posedge clk);
        #1;
        check($sformatf("rnd%0d_hold_done", i), 64'(done), 64'd0);
        check($sformatf("rnd%0d_hold_out", i), 64'(alu_out), 64'(held));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
